// File: rtl/gcm_stream_tx.sv
// rtl/gcm_stream_tx.sv - serializes KEY, IV, AAD, PT and a generated LEN block onto the GCM core din port
module gcm_stream_tx #(
    parameter int DATA_W = 32,
    parameter int BLK_W  = 128,
    parameter int CNT_W  = 8,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              job_start,
    input  logic              job_mode,
    input  logic [CNT_W-1:0]  job_aad_blks,
    input  logic [CNT_W-1:0]  job_pt_blks,
    output logic              job_busy,
    output logic              job_done,
    input  logic [BLK_W-1:0]  blk_data,
    input  logic              blk_valid,
    output logic              blk_ready,
    output logic              En_Trig_in,
    output logic              Mod_in,
    output logic [DATA_W-1:0] din,
    output logic              din_dv
);
    localparam int WPB  = BLK_W / DATA_W;
    localparam int WC_W = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int GC_W = 16;
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WPB - 1);
    localparam logic [GC_W-1:0] GAP_LAST  = GC_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_KEY, S_IV, S_AAD, S_PT, S_LEN, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        P_LOAD, P_SHIFT, P_GAP
    } phase_t;

    state_t            r_state, w_state_nxt;
    phase_t            r_phase, w_phase_nxt;
    logic              r_mode;
    logic [CNT_W-1:0]  r_aad_n;
    logic [CNT_W-1:0]  r_pt_n;
    logic [CNT_W-1:0]  r_blk;
    logic [BLK_W-1:0]  r_shift;
    logic [WC_W-1:0]   r_word;
    logic [GC_W-1:0]   r_gap;

    logic              w_blk_done;
    logic              w_load_len;
    logic              w_hs;
    logic              w_in_blk;
    logic [127:0]      w_len_blk128;
    logic [BLK_W-1:0]  w_len_blk;

    // GHASH length block: AAD and payload bit lengths in two 64-bit fields
    assign w_len_blk128 = {64'(r_aad_n) << 7, 64'(r_pt_n) << 7};
    assign w_len_blk    = BLK_W'(w_len_blk128);

    assign w_in_blk   = (r_state == S_KEY) || (r_state == S_IV) ||
                        (r_state == S_AAD) || (r_state == S_PT);
    assign blk_ready  = w_in_blk && (r_phase == P_LOAD);
    assign w_hs       = blk_ready && blk_valid;
    assign din_dv     = (w_in_blk || (r_state == S_LEN)) && (r_phase == P_SHIFT);
    assign din        = din_dv ? r_shift[BLK_W-1 -: DATA_W] : '0;
    assign job_busy   = (r_state != S_IDLE);
    assign job_done   = (r_state == S_DONE);
    assign En_Trig_in = (r_state == S_TRIG);
    assign Mod_in     = r_mode;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_phase <= P_LOAD;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_blk_done  = 1'b0;
        w_load_len  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (job_start) begin
                    w_state_nxt = S_TRIG;
                end
            end
            S_TRIG: begin
                w_state_nxt = S_KEY;
                w_phase_nxt = P_LOAD;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                case (r_phase)
                    P_LOAD: begin
                        if (blk_valid) begin
                            w_phase_nxt = P_SHIFT;
                        end
                    end
                    P_SHIFT: begin
                        if (r_word == WORD_LAST) begin
                            if (GAP == 0) begin
                                w_blk_done = 1'b1;
                            end else begin
                                w_phase_nxt = P_GAP;
                            end
                        end
                    end
                    default: begin
                        if (r_gap == GAP_LAST) begin
                            w_blk_done = 1'b1;
                        end
                    end
                endcase
                if (w_blk_done) begin
                    w_phase_nxt = P_LOAD;
                    case (r_state)
                        S_KEY: w_state_nxt = S_IV;
                        S_IV: begin
                            if (r_aad_n != '0) begin
                                w_state_nxt = S_AAD;
                            end else if (r_pt_n != '0) begin
                                w_state_nxt = S_PT;
                            end else begin
                                w_state_nxt = S_LEN;
                            end
                        end
                        S_AAD: begin
                            if (r_blk == r_aad_n - CNT_W'(1)) begin
                                w_state_nxt = (r_pt_n != '0) ? S_PT : S_LEN;
                            end
                        end
                        S_PT: begin
                            if (r_blk == r_pt_n - CNT_W'(1)) begin
                                w_state_nxt = S_LEN;
                            end
                        end
                        default: w_state_nxt = S_DONE;
                    endcase
                end
            end
        endcase
        // LEN has no upstream handshake: load the generated block and start shifting at once
        if ((w_state_nxt == S_LEN) && (r_state != S_LEN)) begin
            w_load_len  = 1'b1;
            w_phase_nxt = P_SHIFT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode  <= 1'b0;
            r_aad_n <= '0;
            r_pt_n  <= '0;
            r_blk   <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_gap   <= '0;
        end else begin
            if ((r_state == S_IDLE) && job_start) begin
                r_mode  <= job_mode;
                r_aad_n <= job_aad_blks;
                r_pt_n  <= job_pt_blks;
                r_blk   <= '0;
            end
            if (w_load_len) begin
                r_shift <= w_len_blk;
                r_word  <= '0;
            end else if (w_hs) begin
                r_shift <= blk_data;
                r_word  <= '0;
            end else if (din_dv) begin
                r_shift <= r_shift << DATA_W;
                r_word  <= (r_word == WORD_LAST) ? '0 : r_word + WC_W'(1);
            end
            if (r_phase == P_GAP) begin
                r_gap <= (r_gap == GAP_LAST) ? '0 : r_gap + GC_W'(1);
            end
            if (w_blk_done) begin
                r_blk <= (w_state_nxt == r_state) ? r_blk + CNT_W'(1) : '0;
            end
        end
    end

endmodule
